// File: rtl/uart_cmd_parser.sv
// ASCII command parser: turns "R<addr>CR/LF" / "W<addr><data>CR/LF" byte streams into single-cycle bus requests.
// Latency: valid_o/error_o are registered and appear 1 clock after the terminating or offending byte strobe.
// Backpressure: none; downstream must take valid_o in the cycle it is asserted, UART bytes are never stalled.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   received, rx_byte   one-cycle byte strobe and byte from the UART receiver
//   recv_error          one-cycle UART framing-error strobe (aborts any message)
//   addr_o, data_o, rw_o  request fields, held until the next valid_o
//   valid_o, error_o    one-cycle request / message-discarded strobes
//   busy_o              high while a message is partially received
module uart_cmd_parser #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  recv_error,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  error_o,
    output logic                  busy_o
);

    localparam int NA   = ADDR_WIDTH / 4;
    localparam int ND   = DATA_WIDTH / 4;
    localparam int MAXD = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(MAXD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        EOL  = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_sr, addr_sr_n;
    logic [DATA_WIDTH-1:0]   data_sr, data_sr_n;
    logic                    rw_sr, rw_sr_n;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic                    rw_n, valid_n, error_n;

    logic                    is_hex;
    logic [3:0]              nib;
    logic                    is_term;

    // Hex decode of the incoming byte; non-hex bytes leave is_hex low.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'd0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            nib = rx_byte[3:0];
        end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                     (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
            nib = rx_byte[3:0] + 4'd9;   // 'A'/'a' low nibble is 1 -> 10
        end else begin
            is_hex = 1'b0;
        end
    end

    assign is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_sr_n = addr_sr;
        data_sr_n = data_sr;
        rw_sr_n   = rw_sr;
        addr_n    = addr_o;
        data_n    = data_o;
        rw_n      = rw_o;
        valid_n   = 1'b0;
        error_n   = 1'b0;

        if (recv_error) begin
            // Framing error overrides any byte in the same cycle.
            error_n = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
        end else if (received) begin
            unique case (state)
                IDLE: begin
                    if (rx_byte == 8'h52 || rx_byte == 8'h57) begin
                        state_n   = ADDR;
                        rw_sr_n   = (rx_byte == 8'h57);
                        cnt_n     = '0;
                        addr_sr_n = '0;
                        data_sr_n = '0;
                    end else if (!is_term) begin
                        error_n = 1'b1;   // stray CR/LF between messages is tolerated
                    end
                end
                ADDR: begin
                    if (is_hex) begin
                        // Truncating cast implements the left shift: first digit ends up MSB.
                        addr_sr_n = ADDR_WIDTH'({addr_sr, nib});
                        if (cnt == CW'(NA - 1)) begin
                            cnt_n   = '0;
                            state_n = rw_sr ? DATA : EOL;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        error_n = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        data_sr_n = DATA_WIDTH'({data_sr, nib});
                        if (cnt == CW'(ND - 1)) begin
                            cnt_n   = '0;
                            state_n = EOL;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        error_n = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                EOL: begin
                    if (is_term) begin
                        valid_n = 1'b1;
                        addr_n  = addr_sr;
                        data_n  = rw_sr ? data_sr : '0;
                        rw_n    = rw_sr;
                    end else begin
                        error_n = 1'b1;
                    end
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_sr <= '0;
            data_sr <= '0;
            rw_sr   <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
            error_o <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_sr <= addr_sr_n;
            data_sr <= data_sr_n;
            rw_sr   <= rw_sr_n;
            addr_o  <= addr_n;
            data_o  <= data_n;
            rw_o    <= rw_n;
            valid_o <= valid_n;
            error_o <= error_n;
        end
    end

    assign busy_o = (state != IDLE);

endmodule
